cdb_rr_arbiter: RTL and testbench
=================================

Name: cdb_rr_arbiter

Overview:
Parametrised common data bus arbiter; successor to the fixed 2-FU/2-lane CDB. Arbitrates FU_NUM completing functional units onto CDB_WIDTH broadcast lanes using a rotating round-robin priority. Grants back to the FUs combinationally, broadcasts on a registered CDB, and supports a flush. Sits between the FU completion stage and the RS/ROB/map-table wakeup logic.

Parameters:
FU_NUM, 4, number of requesting functional units
CDB_WIDTH, 2, number of CDB broadcast lanes per cycle (1..FU_NUM)
PREG_NUM, 64, physical register count; TAG_W = $clog2(PREG_NUM)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset (reset==0 resets on posedge clk)
flush_i  in  1  squash: no grants this cycle, kill pending broadcast
FU_complete_i  in  FU_NUM  per-FU completion request (valid)
completed_tag_i  in  FU_NUM x TAG_W  per-FU destination preg tag
FU_complete_en_o  out  FU_NUM  per-FU grant (combinational)
CDB_en_o  out  CDB_WIDTH  per-lane broadcast valid (registered)
CDB_o  out  CDB_WIDTH x TAG_W  per-lane broadcast tag (registered)

Behaviour:
- Handshake: FU holds FU_complete_i=1 and a stable tag until it sees FU_complete_en_o=1 in the same cycle; the transfer happens at that posedge.
- Priority: state register rr_ptr (clog2(FU_NUM) bits). Scan FU indices rr_ptr, rr_ptr+1, ... mod FU_NUM; the first CDB_WIDTH requesters are granted.
- Lane mapping: k-th granted FU in scan order drives lane k; lanes fill from lane 0 upward, no holes.
- Grant is 0 whenever reset==0 or flush_i==1.
- Pointer update: if any grant, rr_ptr <= (scan-order last granted index + 1) mod FU_NUM; otherwise hold.
- Output register, posedge: CDB_en_o[k] <= lane k used; CDB_o[k] <= its tag, or 0 if unused. Latency: grant cycle N -> broadcast cycle N+1.
- Flush: CDB_en_o and CDB_o clear to 0 next cycle; rr_ptr holds.
- Reset (also mid-operation): rr_ptr=0, CDB_en_o=0, CDB_o=0; FU_complete_en_o=0 while reset==0. Any in-flight broadcast is discarded.
- More than CDB_WIDTH requesters: the excess stay ungranted and keep requesting; no FU waits more than ceil(FU_NUM/CDB_WIDTH) grant cycles.
- CDB_WIDTH >= FU_NUM: every requester is granted each cycle.

Optional Feature:
CDB_BYPASS_EN
- Defined: output register removed. CDB_en_o/CDB_o are combinational from the current grants (zero latency, matching legacy CDB timing). Flush and reset zero them in the same cycle.
- Undefined: registered outputs, one-cycle latency as above.

Decomposition:
- cdb_pkg: TAG_W derivation helper, typedef preg_tag_t, default FU_NUM/CDB_WIDTH constants.
- Sub-module cdb_rr_picker: combinational rotate-and-pick-first-CDB_WIDTH. Inputs: request vector, rr_ptr. Outputs: grant vector, per-lane FU index/valid, next pointer.
- Top holds rr_ptr, the flush/reset gating and the output register.

Test Plan (FU_NUM=4, CDB_WIDTH=2, registered):
1. After reset, req=4'b1111, tags 3/5/7/9 -> grant 4'b0011; next cycle CDB_en_o=2'b11, CDB_o[0]=3, CDB_o[1]=5, rr_ptr=2.
2. Continue: req=4'b1100 held -> grant 4'b1100; next cycle CDB_o[0]=7, CDB_o[1]=9; rr_ptr=0.
3. Wrap: rr_ptr=3, req=4'b1001, FU0 tag 10, FU3 tag 20 -> grant 4'b1001; next cycle CDB_o[0]=20, CDB_o[1]=10; rr_ptr=1.
4. Single/none: req=4'b0100, tag 12 -> next cycle CDB_en_o=2'b01, CDB_o[0]=12, CDB_o[1]=0. Then req=0 -> CDB_en_o=0, rr_ptr unchanged.
5. Flush: req=4'b1111 with flush_i=1 -> grant 0; next cycle CDB_en_o=0, rr_ptr unchanged.
6. Reset mid-operation: grant issued, reset=0 at that posedge -> CDB_en_o=0, CDB_o=0, rr_ptr=0. Repeat with CDB_BYPASS_EN: outputs equal the same-cycle grants.

Source files
------------

// File: rtl/cdb_pkg.sv
`default_nettype none
// ==== cdb_pkg: shared constants, tag type and width helper for the CDB arbiter (rev 1.0) ====
package cdb_pkg;

   localparam int CDB_FU_NUM_DEF   = 4;
   localparam int CDB_WIDTH_DEF    = 2;
   localparam int CDB_PREG_NUM_DEF = 64;

   // Width of an index over n items, never below one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int TAG_W_DEF = clog2_min1(CDB_PREG_NUM_DEF);

   typedef logic [TAG_W_DEF-1:0] preg_tag_t;

endpackage
`default_nettype wire

// File: rtl/cdb_rr_picker.sv
`default_nettype none
// ==== cdb_rr_picker: rotate from ptr_i and pick the first CDB_WIDTH requesters (rev 1.0) ====
module cdb_rr_picker
   import cdb_pkg::*;
#(
   parameter int FU_NUM    = CDB_FU_NUM_DEF,
   parameter int CDB_WIDTH = CDB_WIDTH_DEF,
   parameter int PTR_W     = clog2_min1(FU_NUM)
) (
   input  logic [FU_NUM-1:0]          req_i,
   input  logic [PTR_W-1:0]           ptr_i,
   output logic [FU_NUM-1:0]          grant_o,
   output logic [CDB_WIDTH-1:0]       lane_vld_o,
   output logic [CDB_WIDTH*PTR_W-1:0] lane_idx_o,
   output logic [PTR_W-1:0]           next_ptr_o
);

   int idx;
   int cnt;
   int last;

   always_comb begin
      grant_o    = '0;
      lane_vld_o = '0;
      lane_idx_o = '0;
      next_ptr_o = ptr_i;
      idx        = 0;
      cnt        = 0;
      last       = 0;
      // Lanes are filled in scan order, so lane k always holds the k-th winner.
      for (int i = 0; i < FU_NUM; i++) begin
         idx = (int'(ptr_i) + i) % FU_NUM;
         if (req_i[idx] && (cnt < CDB_WIDTH)) begin
            grant_o[idx]                      = 1'b1;
            lane_vld_o[cnt]                   = 1'b1;
            lane_idx_o[cnt*PTR_W +: PTR_W]    = PTR_W'(idx);
            last                              = idx;
            cnt                               = cnt + 1;
         end
      end
      if (cnt != 0) begin
         next_ptr_o = PTR_W'((last + 1) % FU_NUM);
      end
   end

endmodule
`default_nettype wire

// File: rtl/cdb_rr_arbiter.sv
`default_nettype none
// ==== cdb_rr_arbiter: round-robin CDB arbiter, FU_NUM units onto CDB_WIDTH lanes (rev 1.0) ====
// Define CDB_BYPASS_EN for combinational (zero-latency) CDB outputs.
module cdb_rr_arbiter
   import cdb_pkg::*;
#(
   parameter int FU_NUM    = CDB_FU_NUM_DEF,
   parameter int CDB_WIDTH = CDB_WIDTH_DEF,
   parameter int PREG_NUM  = CDB_PREG_NUM_DEF
) (
   input  logic                                          clk,
   input  logic                                          reset,
   input  logic                                          flush_i,
   input  logic [FU_NUM-1:0]                             FU_complete_i,
   input  logic [FU_NUM*clog2_min1(PREG_NUM)-1:0]        completed_tag_i,
   output logic [FU_NUM-1:0]                             FU_complete_en_o,
   output logic [CDB_WIDTH-1:0]                          CDB_en_o,
   output logic [CDB_WIDTH*clog2_min1(PREG_NUM)-1:0]     CDB_o
);

   localparam int TAG_W = clog2_min1(PREG_NUM);
   localparam int PTR_W = clog2_min1(FU_NUM);

   logic [PTR_W-1:0]           rr_ptr_q;
   logic [PTR_W-1:0]           rr_ptr_d;
   logic [FU_NUM-1:0]          req_gated;
   logic [CDB_WIDTH-1:0]       lane_vld;
   logic [CDB_WIDTH*PTR_W-1:0] lane_idx;
   logic [CDB_WIDTH-1:0]       cdb_en_d;
   logic [CDB_WIDTH*TAG_W-1:0] cdb_tag_d;

   // Masking requests (rather than grants) keeps the pointer frozen on flush/reset too.
   assign req_gated = (reset && !flush_i) ? FU_complete_i : '0;

   cdb_rr_picker #(
      .FU_NUM    (FU_NUM),
      .CDB_WIDTH (CDB_WIDTH),
      .PTR_W     (PTR_W)
   ) u_picker (
      .req_i      (req_gated),
      .ptr_i      (rr_ptr_q),
      .grant_o    (FU_complete_en_o),
      .lane_vld_o (lane_vld),
      .lane_idx_o (lane_idx),
      .next_ptr_o (rr_ptr_d)
   );

   always_comb begin
      cdb_en_d  = lane_vld;
      cdb_tag_d = '0;
      for (int k = 0; k < CDB_WIDTH; k++) begin
         if (lane_vld[k]) begin
            cdb_tag_d[k*TAG_W +: TAG_W] =
               completed_tag_i[int'(lane_idx[k*PTR_W +: PTR_W])*TAG_W +: TAG_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

`ifdef CDB_BYPASS_EN
   assign CDB_en_o = cdb_en_d;
   assign CDB_o    = cdb_tag_d;
`else
   logic [CDB_WIDTH-1:0]       cdb_en_q;
   logic [CDB_WIDTH*TAG_W-1:0] cdb_tag_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         cdb_en_q  <= '0;
         cdb_tag_q <= '0;
      end else begin
         cdb_en_q  <= cdb_en_d;
         cdb_tag_q <= cdb_tag_d;
      end
   end

   assign CDB_en_o = cdb_en_q;
   assign CDB_o    = cdb_tag_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_rr_arbiter.sv
`default_nettype none
// ==== tb_cdb_rr_arbiter: directed self-checking bench, FU_NUM=4, CDB_WIDTH=2 (rev 1.0) ====
module tb_cdb_rr_arbiter;
   import cdb_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        flush_i;
   logic [3:0]  FU_complete_i;
   logic [23:0] completed_tag_i;
   logic [3:0]  FU_complete_en_o;
   logic [1:0]  CDB_en_o;
   logic [11:0] CDB_o;

   int n_cmp  = 0;
   int n_fail = 0;

   cdb_rr_arbiter #(
      .FU_NUM    (4),
      .CDB_WIDTH (2),
      .PREG_NUM  (64)
   ) dut (
      .clk              (clk),
      .reset            (reset),
      .flush_i          (flush_i),
      .FU_complete_i    (FU_complete_i),
      .completed_tag_i  (completed_tag_i),
      .FU_complete_en_o (FU_complete_en_o),
      .CDB_en_o         (CDB_en_o),
      .CDB_o            (CDB_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_tags(input preg_tag_t t0, input preg_tag_t t1,
                           input preg_tag_t t2, input preg_tag_t t3);
      completed_tag_i = {t3, t2, t1, t0};
   endtask

   // Drive at negedge, check grant before the posedge, CDB when it is due, pointer after.
   task automatic step(input string name, input logic rst_n, input logic fl, input logic [3:0] req,
                       input logic [3:0] eg, input logic [1:0] ee, input preg_tag_t e0,
                       input preg_tag_t e1, input logic [1:0] ep);
      @(negedge clk);
      reset         = rst_n;
      flush_i       = fl;
      FU_complete_i = req;
      #1;
      chk({name, ".grant"}, 32'(FU_complete_en_o), 32'(eg));
`ifdef CDB_BYPASS_EN
      chk({name, ".en"},   32'(CDB_en_o),    32'(ee));
      chk({name, ".lane0"}, 32'(CDB_o[5:0]),  32'(e0));
      chk({name, ".lane1"}, 32'(CDB_o[11:6]), 32'(e1));
`endif
      @(posedge clk);
      #1;
`ifndef CDB_BYPASS_EN
      chk({name, ".en"},   32'(CDB_en_o),    32'(ee));
      chk({name, ".lane0"}, 32'(CDB_o[5:0]),  32'(e0));
      chk({name, ".lane1"}, 32'(CDB_o[11:6]), 32'(e1));
`endif
      chk({name, ".ptr"}, 32'(dut.rr_ptr_q), 32'(ep));
   endtask

   initial begin
      reset         = 1'b0;
      flush_i       = 1'b0;
      FU_complete_i = 4'b0000;
      set_tags(6'd3, 6'd5, 6'd7, 6'd9);

      // Held in reset with all FUs requesting: nothing granted or broadcast.
      step("rst_hold", 1'b0, 1'b0, 4'b1111, 4'b0000, 2'b00, 6'd0, 6'd0, 2'd0);

      // From pointer 0, FU0/FU1 win; pointer moves past FU1.
      step("all_req", 1'b1, 1'b0, 4'b1111, 4'b0011, 2'b11, 6'd3, 6'd5, 2'd2);
      // Remaining FU2/FU3 served next; pointer wraps to 0.
      step("upper", 1'b1, 1'b0, 4'b1100, 4'b1100, 2'b11, 6'd7, 6'd9, 2'd0);

      // Single requester lands on lane 0 only.
      set_tags(6'd0, 6'd0, 6'd12, 6'd0);
      step("single", 1'b1, 1'b0, 4'b0100, 4'b0100, 2'b01, 6'd12, 6'd0, 2'd3);

      // Wrap: scan 3,0 puts FU3 on lane 0 and FU0 on lane 1.
      set_tags(6'd10, 6'd0, 6'd0, 6'd20);
      step("wrap", 1'b1, 1'b0, 4'b1001, 4'b1001, 2'b11, 6'd20, 6'd10, 2'd1);

      step("idle", 1'b1, 1'b0, 4'b0000, 4'b0000, 2'b00, 6'd0, 6'd0, 2'd1);

      // Grant FU1/FU2, then flush the next cycle with everyone requesting.
      set_tags(6'd3, 6'd5, 6'd7, 6'd9);
      step("pre_flush", 1'b1, 1'b0, 4'b1111, 4'b0110, 2'b11, 6'd5, 6'd7, 2'd3);
      step("flush", 1'b1, 1'b1, 4'b1111, 4'b0000, 2'b00, 6'd0, 6'd0, 2'd3);

      // After flush, pointer 3 still in force: FU3 then FU0.
      step("post_flush", 1'b1, 1'b0, 4'b1111, 4'b1001, 2'b11, 6'd9, 6'd3, 2'd1);

      // Reset mid-operation with requests pending.
      step("rst_mid", 1'b0, 1'b0, 4'b1111, 4'b0000, 2'b00, 6'd0, 6'd0, 2'd0);
      step("post_rst", 1'b1, 1'b0, 4'b0010, 4'b0010, 2'b01, 6'd5, 6'd0, 2'd2);

      // Three requesters from pointer 2: FU2/FU3 win, FU1 waits one round.
      step("excess", 1'b1, 1'b0, 4'b1110, 4'b1100, 2'b11, 6'd7, 6'd9, 2'd0);
      step("excess2", 1'b1, 1'b0, 4'b0010, 4'b0010, 2'b01, 6'd5, 6'd0, 2'd2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
